// File: rtl/tm1638_value_formatter.sv
// Binary 0..999 to three 7-segment codes for the TM1638 driver.
// Sequential double-dabble; codes change only while synch2 is low.
module tm1638_value_formatter #(
  parameter int SYNC_LOW = 2000,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] value,
  input  logic       load,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic       synch2,
  output logic       busy,
  output logic       ovf,
  output logic       frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_ENC  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [15:0] HOLD_LAST = 16'(SYNC_LOW - 1);

  logic [1:0]  state;
  logic [9:0]  val_q;
  logic [9:0]  sh;
  logic [11:0] bcd;
  logic [3:0]  bit_cnt;
  logic [15:0] hold_cnt;
  logic        pend;
  logic [9:0]  pend_val;

  logic [11:0] adj;
  logic [7:0]  d1_n;
  logic [7:0]  d2_n;
  logic [7:0]  d3_n;
  logic        ovf_n;

  function automatic logic [3:0] fix(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h40;
    endcase
    return s;
  endfunction

  // Add-3 correction and segment encode of the finished BCD digits
  always_comb begin
    adj   = {fix(bcd[11:8]), fix(bcd[7:4]), fix(bcd[3:0])};
    ovf_n = (val_q > 10'd999);
    d1_n  = seg(bcd[11:8]);
    d2_n  = seg(bcd[7:4]);
    d3_n  = seg(bcd[3:0]);
    if (ovf_n) begin
      d1_n = 8'h40;
      d2_n = 8'h40;
      d3_n = 8'h40;
    end else if (BLANK_LZ != 0) begin
      if (bcd[11:8] == 4'd0) begin
        d1_n = 8'h00;
        if (bcd[7:4] == 4'd0) d2_n = 8'h00;
      end
    end
  end

  // Frame sequencer: accept, convert, encode, hold synch2 low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      val_q      <= '0;
      sh         <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      pend       <= 1'b0;
      pend_val   <= '0;
      data1      <= 8'h00;
      data2      <= 8'h00;
      data3      <= 8'h00;
      synch2     <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load && state != S_IDLE) begin
        pend     <= 1'b1;
        pend_val <= value;
      end
      case (state)
        S_IDLE: begin
          if (load || pend) begin
            val_q   <= load ? value : pend_val;
            sh      <= load ? value : pend_val;
            bcd     <= '0;
            pend    <= 1'b0;
            busy    <= 1'b1;
            synch2  <= 1'b0;
            bit_cnt <= '0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd     <= 12'({adj, sh[9]});
          sh      <= {sh[8:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state <= S_ENC;
        end
        S_ENC: begin
          data1    <= d1_n;
          data2    <= d2_n;
          data3    <= d3_n;
          ovf      <= ovf_n;
          hold_cnt <= '0;
          state    <= S_HOLD;
        end
        default: begin
          hold_cnt <= hold_cnt + 16'd1;
          if (hold_cnt == HOLD_LAST) begin
            synch2     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_value_formatter.sv
// Bench for tm1638_value_formatter: directed frames plus random values
// against a decimal-arithmetic display model.
module tb_tm1638_value_formatter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] value = '0;
  logic       load = 1'b0;

  logic [7:0] a1, a2, a3, b1, b2, b3;
  logic       as2, abusy, aovf, afd;
  logic       bs2, bbusy, bovf, bfd;

  int checks = 0;
  int failures = 0;

  logic [7:0] seg_t [10];

  always #5 clk = ~clk;

  tm1638_value_formatter #(.SYNC_LOW(4), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .data1(a1), .data2(a2), .data3(a3), .synch2(as2),
    .busy(abusy), .ovf(aovf), .frame_done(afd)
  );

  tm1638_value_formatter #(.SYNC_LOW(4), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .data1(b1), .data2(b2), .data3(b3), .synch2(bs2),
    .busy(bbusy), .ovf(bovf), .frame_done(bfd)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model(input int v, input bit blank,
                       output logic [7:0] e1, output logic [7:0] e2,
                       output logic [7:0] e3, output logic eo);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (v > 999) begin
      e1 = 8'h40; e2 = 8'h40; e3 = 8'h40; eo = 1'b1;
    end else begin
      e1 = (blank && h == 0) ? 8'h00 : seg_t[h];
      e2 = (blank && h == 0 && t == 0) ? 8'h00 : seg_t[t];
      e3 = seg_t[u];
      eo = 1'b0;
    end
  endtask

  task automatic chk_codes(input int v);
    logic [7:0] e1, e2, e3;
    logic eo;
    model(v, 1'b1, e1, e2, e3, eo);
    chk($sformatf("blank_codes v=%0d", v), {8'h0, a1, a2, a3},
        {8'h0, e1, e2, e3});
    chk($sformatf("blank_ovf v=%0d", v), 32'(aovf), 32'(eo));
    model(v, 1'b0, e1, e2, e3, eo);
    chk($sformatf("full_codes v=%0d", v), {8'h0, b1, b2, b3},
        {8'h0, e1, e2, e3});
  endtask

  task automatic frame(input int v);
    load = 1'b1;
    value = 10'(v);
    tick();
    load = 1'b0;
    chk("e0_busy", 32'(abusy), 32'd1);
    chk("e0_synch2", 32'(as2), 32'd0);
    repeat (11) tick();
    chk_codes(v);
    chk("e11_synch2", 32'(as2), 32'd0);
    repeat (3) tick();
    chk("e14_synch2", 32'(as2), 32'd0);
    chk("e14_busy", 32'(abusy), 32'd1);
    tick();
    chk("e15_rise", {29'd0, as2, afd, abusy}, {29'd0, 3'b110});
    chk("e15_rise_b", 32'(bs2), 32'd1);
    tick();
    chk("e16_idle", {30'd0, as2, afd}, {30'd0, 2'b10});
  endtask

  logic [7:0] p1, p2, p3;
  logic       ps2;
  logic       prim = 1'b0;

  // Codes must hold steady across every cycle pair with synch2 high
  always @(negedge clk) begin
    if (!rst && prim && ps2 && as2)
      chk("stable_while_synch2", {8'h0, a1, a2, a3}, {8'h0, p1, p2, p3});
    p1 <= a1;
    p2 <= a2;
    p3 <= a3;
    ps2 <= as2;
    prim <= !rst;
  end

  initial begin
    seg_t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    repeat (3) tick();
    chk("reset_out", {a1, a2, a3, 8'(as2)}, 32'h0);
    chk("reset_flags", {29'd0, abusy, aovf, afd}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {30'd0, as2, abusy}, 32'h0);

    frame(123);
    frame(7);
    frame(1000);
    frame(999);
    frame(0);

    load = 1'b1;
    value = 10'd456;
    tick();
    load = 1'b0;
    repeat (2) tick();
    load = 1'b1;
    value = 10'd789;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    value = 10'd321;
    tick();
    load = 1'b0;
    repeat (6) tick();
    chk_codes(456);
    repeat (4) tick();
    chk("pend_rise", {30'd0, as2, afd}, {30'd0, 2'b11});
    tick();
    chk("pend_drop", {30'd0, as2, abusy}, {30'd0, 2'b01});
    repeat (11) tick();
    chk_codes(321);
    repeat (4) tick();
    chk("pend2_rise", {30'd0, as2, afd}, {30'd0, 2'b11});
    tick();
    chk("pend2_idle", {30'd0, as2, abusy}, {30'd0, 2'b10});

    load = 1'b1;
    value = 10'd555;
    tick();
    load = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("async_rst_data", {8'h0, a1, a2, a3}, 32'h0);
    chk("async_rst_flags", {28'd0, as2, abusy, aovf, afd}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("no_frame_after_rst", {30'd0, as2, afd}, 32'h0);
    end
    frame(845);

    for (int i = 0; i < 14; i++) begin
      frame(int'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_value_formatter.md
Name: tm1638_value_formatter

Overview:
- Upstream feeder for the TM1638 display driver. Converts a binary value (0..999) into three 7-segment codes for the driver's data1/data2/data3 inputs, and generates the driver's synch2 frame-qualify level.
- Conversion is sequential double-dabble; data changes only while synch2 is low, so the driver latches stable codes on the synch2 rising edge.

Parameters:
- SYNC_LOW, 2000: clk cycles synch2 is held low after the code update. Range 1..65535. Default exceeds one driver slow-clock period.
- BLANK_LZ, 1: 1 = blank leading zeros in hundreds/tens; 0 = always show three digits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- value  in  10  binary value to display
- load  in  1  request to display value; sampled on posedge clk
- data1  out  8  hundreds segment code
- data2  out  8  tens segment code
- data3  out  8  units segment code
- synch2  out  1  frame qualify to driver; rising edge = codes valid
- busy  out  1  high from load acceptance until synch2 rises
- ovf  out  1  last accepted value was >999
- frame_done  out  1  one-cycle pulse coincident with synch2 rising

Behaviour:
- Reset (async, immediate): data1/2/3=8'h00, synch2=0, busy=0, ovf=0, frame_done=0, pending cleared, state IDLE.
- Reset mid-frame aborts the frame. Outputs return to reset values regardless of state.
- Segment encoding: bit0=a..bit6=g, bit7 (DP)=0.
  - Digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Dash: 40. Blank: 00.
- States: IDLE, CONV, ENC, HOLD.
- IDLE:
  - synch2 holds its value (1 after any completed frame, 0 after reset).
  - On an edge with load=1, or pending=1: accept. New load has priority over pending; pending is cleared either way.
  - On accept: latch value, busy<=1, synch2<=0, shift counter<=0, go to CONV. Call this edge E0.
- CONV: one double-dabble shift per edge, on E1..E10. BCD registers are 12 bits, with add-3 on any nibble >=5 before each shift. After E10, go to ENC.
- ENC (edge E11):
  - Register data1/2/3 from the BCD digits.
  - If latched value >999: all three = 8'h40, ovf<=1. Otherwise ovf<=0.
  - With BLANK_LZ=1: hundreds=0 gives data1=00; hundreds=0 and tens=0 gives data2=00. data3 is never blanked.
  - Hold counter<=0, go to HOLD.
- HOLD:
  - Counter increments each edge.
  - On the edge where counter==SYNC_LOW-1: synch2<=1, busy<=0, frame_done<=1 for one cycle, go to IDLE.
- Latency: synch2 rises on edge E11+SYNC_LOW. data1/2/3 become stable SYNC_LOW cycles before synch2 rises.
- data1/2/3 change only in ENC. They never change while synch2=1.
- Load while busy (CONV/ENC/HOLD): value goes to pending_val and pending<=1. Last one wins; no loss of the latest request.
- synch2 stays high for at least one full cycle in IDLE before a pending or new accept drops it again.
- Simultaneous load and pending in IDLE: load value used, pending discarded.
- load held high continuously: back-to-back frames, each with the minimum 1-cycle synch2 high.

Test Plan:
- Reset, then load=1 value=10'd123 (SYNC_LOW=4, BLANK_LZ=1) -> data1=06, data2=5B, data3=4F at E11; synch2 low E0..E14, rises at E15; frame_done 1 cycle at E15; busy low at E15.
- value=7, BLANK_LZ=1 -> data1=00, data2=00, data3=07. Same value with BLANK_LZ=0 -> 3F, 3F, 07.
- value=10'd1000 -> data1..3=40 and ovf=1. Next value=999 -> 6F, 6F, 6F and ovf=0.
- Load 456 at E0, then load 789 at E3 and load 321 at E5 -> first frame shows 66, 6D, 7D. synch2 high exactly 1 cycle, then second frame shows 4F, 5B, 06. 789 is never displayed.
- Assert rst at E6 of a frame -> all outputs immediately 00/0; no frame_done. The next load runs a full frame from E0.
- Check across all frames: data1/2/3 never change while synch2=1; value=0 with BLANK_LZ=1 -> 00, 00, 3F.
